// File: rtl/tdoa_result_packer.sv
// tdoa_result_packer: latches three mic timestamps, computes signed deltas vs mic 1,
// presents them under valid/ack, then pulses rearm and waits for the inputs to clear.
module tdoa_result_packer #(
    parameter int TIME_W       = 32,
    parameter int MAX_SPREAD   = 64,
    parameter int REARM_CYCLES = 4
) (
    input  logic                     pcm_clk,
    input  logic                     reset,
    input  logic [TIME_W-1:0]        trigger_time_1,
    input  logic [TIME_W-1:0]        trigger_time_2,
    input  logic [TIME_W-1:0]        trigger_time_3,
    input  logic                     cpu_ack,
    output logic                     result_valid,
    output logic signed [TIME_W-1:0] delta_21,
    output logic signed [TIME_W-1:0] delta_31,
    output logic [1:0]               first_mic,
    output logic                     out_of_range,
    output logic [15:0]              event_count,
    output logic                     rearm
);
    localparam int CW = $clog2(REARM_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, COMPUTE, PRESENT, REARM, WAIT_CLEAR} state_t;

    state_t                   state, state_n;
    logic [TIME_W-1:0]        t1, t2, t3;
    logic [CW-1:0]            cnt, cnt_n;
    logic                     rearm_n, valid_n;
    logic                     all_set, all_clear;
    logic signed [TIME_W-1:0] d21, d31, lo, hi, mn, mx;
    logic [TIME_W:0]          spread;
    logic [1:0]               first_n;

    assign all_set   = (trigger_time_1 != '0) && (trigger_time_2 != '0) && (trigger_time_3 != '0);
    assign all_clear = (trigger_time_1 == '0) && (trigger_time_2 == '0) && (trigger_time_3 == '0);

    // Modular subtraction read as two's complement absorbs sample-counter wrap.
    always_comb begin
        d21     = t2 - t1;
        d31     = t3 - t1;
        lo      = (d21 < d31) ? d21 : d31;
        hi      = (d21 < d31) ? d31 : d21;
        mn      = lo[TIME_W-1] ? lo : '0;
        mx      = hi[TIME_W-1] ? '0 : hi;
        spread  = {mx[TIME_W-1], mx} - {mn[TIME_W-1], mn};
        first_n = (!d21[TIME_W-1] && !d31[TIME_W-1]) ? 2'd1 : (d21 <= d31) ? 2'd2 : 2'd3;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rearm_n = rearm;
        valid_n = result_valid;
        case (state)
            IDLE:       state_n = all_set ? COMPUTE : IDLE;
            COMPUTE: begin
                state_n = PRESENT;
                valid_n = 1'b1;
            end
            PRESENT: if (cpu_ack) begin
                state_n = REARM;
                valid_n = 1'b0;
                rearm_n = 1'b1;
                cnt_n   = CW'(REARM_CYCLES - 1);
            end
            // rearm stays high while the counter is non-zero, giving REARM_CYCLES cycles
            REARM: begin
                rearm_n = (cnt != '0);
                state_n = (cnt == '0) ? WAIT_CLEAR : REARM;
                cnt_n   = (cnt == '0) ? cnt : cnt - CW'(1);
            end
            WAIT_CLEAR: state_n = all_clear ? IDLE : WAIT_CLEAR;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge pcm_clk) begin
        if (!reset) begin
            state        <= REARM;
            cnt          <= CW'(REARM_CYCLES);
            rearm        <= 1'b0;
            result_valid <= 1'b0;
            t1           <= '0;
            t2           <= '0;
            t3           <= '0;
            delta_21     <= '0;
            delta_31     <= '0;
            first_mic    <= 2'd0;
            out_of_range <= 1'b0;
            event_count  <= 16'd0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            rearm        <= rearm_n;
            result_valid <= valid_n;
            if (state == IDLE && all_set) begin
                t1 <= trigger_time_1;
                t2 <= trigger_time_2;
                t3 <= trigger_time_3;
            end
            if (state == COMPUTE) begin
                delta_21     <= d21;
                delta_31     <= d31;
                first_mic    <= first_n;
                out_of_range <= spread > (TIME_W+1)'(MAX_SPREAD);
                event_count  <= event_count + 16'd1;
            end
        end
    end
endmodule

// File: doc/tdoa_result_packer.md
# tdoa_result_packer

Downstream stage of the three-microphone TDoA block. Captures the three trigger timestamps once all are non-zero and computes the signed arrival differences relative to microphone 1. Flags the earliest microphone and range violations, then holds the result for the CPU under a valid/ack handshake. After the CPU acknowledges, it pulses `rearm`, which drives the TDoA block's active-high reset, and waits for the timestamps to clear before arming again.

## Interface

- `TIME_W`, 32: timestamp width; must equal the sample-counter width.
- `MAX_SPREAD`, 64: largest legal spread between earliest and latest arrival, in samples.
- `REARM_CYCLES`, 4: length of the `rearm` pulse in `pcm_clk` cycles (≥1).

- `pcm_clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `trigger_time_1`/`_2`/`_3`  in  TIME_W each  timestamps from the TDoA block; 0 means "not reported".
- `cpu_ack`  in  1  CPU has read the result; sampled only while `result_valid`=1.
- `result_valid`  out  1  result registers hold a new event.
- `delta_21`, `delta_31`  out  TIME_W signed  t2−t1 and t3−t1, in samples.
- `first_mic`  out  2  index (1..3) of the earliest arrival.
- `out_of_range`  out  1  spread > MAX_SPREAD.
- `event_count`  out  16  number of results presented; wraps 0xFFFF→0.
- `rearm`  out  1  active-high reset request to the TDoA block.

## Operation

- States: IDLE → COMPUTE → PRESENT → REARM → WAIT_CLEAR → IDLE.
- IDLE: if all three inputs are non-zero at an edge, latch them into t1..t3 and go to COMPUTE. Partial non-zero sets are ignored.
- COMPUTE (1 cycle):
  - d21 = (t2−t1) mod 2^TIME_W and d31 = (t3−t1) mod 2^TIME_W, both read as two's complement. Counter wrap is therefore handled naturally.
  - spread = max(0, d21, d31) − min(0, d21, d31), computed at TIME_W+1 bits.
  - `first_mic` = index of the minimum of {0, d21, d31}; ties resolve to the lowest index.
  - Register all outputs, set `result_valid`=1, increment `event_count`, go to PRESENT.
- PRESENT: outputs stay stable. When `cpu_ack`=1 at an edge: clear `result_valid`, set `rearm`=1, load the rearm counter, go to REARM.
- REARM: hold `rearm`=1 for exactly REARM_CYCLES cycles, then clear `rearm` and go to WAIT_CLEAR.
- WAIT_CLEAR: stay until all three inputs are 0, then go to IDLE. This blocks recapture of stale timestamps.
- `cpu_ack` is ignored in every state except PRESENT.
- Result registers (`delta_*`, `first_mic`, `out_of_range`) keep their last values until the next COMPUTE.
- An out-of-range event is still presented, with `out_of_range`=1.

## Timing

- Reset values (while `reset`=0):
  - `result_valid`=0, `rearm`=0, `delta_21`=`delta_31`=0, `first_mic`=0, `out_of_range`=0, `event_count`=0.
- Reset exit: the first edge with `reset`=1 enters REARM, so `rearm` pulses for REARM_CYCLES cycles after release. This flushes any stale upstream state.
- Reset asserted mid-operation: takes effect at the next edge and overrides every state. A pending result is discarded and is not counted.
- Latency: inputs all non-zero at edge E → latched at E → `result_valid` and the result outputs are visible after edge E+1.
- Ack: `cpu_ack` high at edge A while `result_valid`=1 → after A, `result_valid`=0 and `rearm`=1. `rearm` falls after edge A+REARM_CYCLES.
- `cpu_ack` held high continuously acks only once per event; a new event still needs the IDLE capture path.
- Inputs going non-zero during PRESENT or REARM are not captured.
- Boundary case, spread == MAX_SPREAD: `out_of_range`=0.

## Test plan

- Reset then trigger: hold `reset`=0 for 3 cycles. Then apply t1=1000, t2=1005, t3=998 together. Required: `rearm` pulses 4 cycles after release; 2 edges after capture, `result_valid`=1, `delta_21`=5, `delta_31`=−2, `first_mic`=3, `out_of_range`=0, `event_count`=1.
- Handshake: keep inputs non-zero. Assert `cpu_ack` for 1 cycle. Required: `result_valid` falls on the next edge and `rearm`=1 for exactly 4 cycles. No recapture until the inputs return to 0; after they do, reapplying t=(50,50,50) gives deltas 0, `first_mic`=1, `event_count`=2.
- Range: t1=100, t2=165, t3=100 → spread 65, `out_of_range`=1. t2=164 → spread 64, `out_of_range`=0.
- Wrap-around: t1=0xFFFF_FFFE, t2=0x0000_0003, t3=0xFFFF_FFFF → `delta_21`=5, `delta_31`=1, `first_mic`=1.
- Partial and stale inputs: only t1 and t2 non-zero for 10 cycles → no capture. `cpu_ack` pulses in IDLE → no effect.
- Reset mid-PRESENT: assert `reset`=0 for 1 cycle while `result_valid`=1. Required: all outputs return to 0, then `rearm` pulses after release and `event_count` restarts at 0.
